// File: rtl/rv32im_writeback.sv
// Writeback arbiter for ALU / load / muldiv results, with a forwarding copy of the
// last register-file write and a busy scoreboard for long-latency destinations.
module rv32im_writeback #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_BITS = 5
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                alu_valid_i,
  input  logic [REG_BITS-1:0] alu_rd_i,
  input  logic [XLEN-1:0]     alu_data_i,
  input  logic                load_valid_i,
  input  logic [REG_BITS-1:0] load_rd_i,
  input  logic [XLEN-1:0]     load_data_i,
  output logic                load_ready_o,
  input  logic                muldiv_valid_i,
  input  logic [REG_BITS-1:0] muldiv_rd_i,
  input  logic [XLEN-1:0]     muldiv_data_i,
  output logic                muldiv_ready_o,
  input  logic                issue_i,
  input  logic [REG_BITS-1:0] issue_rd_i,
  input  logic [REG_BITS-1:0] rs1_addr_i,
  input  logic [REG_BITS-1:0] rs2_addr_i,
  input  logic [REG_BITS-1:0] chk_rd_i,
  output logic                hazard_o,
  output logic                write_o,
  output logic [REG_BITS-1:0] rd_addr_o,
  output logic [XLEN-1:0]     data_o,
  output logic                fwd_valid_o,
  output logic [REG_BITS-1:0] fwd_addr_o,
  output logic [XLEN-1:0]     fwd_data_o
);

  localparam int unsigned NREGS = 2 ** REG_BITS;

  logic [NREGS-1:0]    busy;
  logic [NREGS-1:0]    busy_next;
  logic                sel_acc;
  logic                sel_long;
  logic [REG_BITS-1:0] sel_rd;
  logic [XLEN-1:0]     sel_data;

  assign load_ready_o   = !alu_valid_i;
  assign muldiv_ready_o = !alu_valid_i && !load_valid_i;

  assign hazard_o = busy[rs1_addr_i] | busy[rs2_addr_i] | busy[chk_rd_i];

  // Fixed priority; the ready outputs above encode the same ordering.
  always_comb begin
    sel_acc  = 1'b0;
    sel_long = 1'b0;
    sel_rd   = '0;
    sel_data = '0;
    if (alu_valid_i) begin
      sel_acc  = 1'b1;
      sel_rd   = alu_rd_i;
      sel_data = alu_data_i;
    end else if (load_valid_i) begin
      sel_acc  = 1'b1;
      sel_long = 1'b1;
      sel_rd   = load_rd_i;
      sel_data = load_data_i;
    end else if (muldiv_valid_i) begin
      sel_acc  = 1'b1;
      sel_long = 1'b1;
      sel_rd   = muldiv_rd_i;
      sel_data = muldiv_data_i;
    end
  end

  // Set is applied after clear so a back-to-back reissue keeps the register pending.
  always_comb begin
    busy_next = busy;
    if (sel_long && (sel_rd != '0)) busy_next[sel_rd] = 1'b0;
    if (issue_i && (issue_rd_i != '0)) busy_next[issue_rd_i] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      write_o     <= 1'b0;
      rd_addr_o   <= '0;
      data_o      <= '0;
      fwd_valid_o <= 1'b0;
      fwd_addr_o  <= '0;
      fwd_data_o  <= '0;
      busy        <= '0;
    end else begin
      fwd_valid_o <= write_o;
      fwd_addr_o  <= rd_addr_o;
      fwd_data_o  <= data_o;
      write_o     <= sel_acc && (sel_rd != '0);
      if (sel_acc) begin
        rd_addr_o <= sel_rd;
        data_o    <= sel_data;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rv32im_writeback.sv
// Bench for rv32im_writeback: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural scoreboard model.
module tb_rv32im_writeback;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid, load_valid, muldiv_valid, issue;
  logic [4:0]  alu_rd, load_rd, muldiv_rd, issue_rd, rs1, rs2, chk_rd;
  logic [31:0] alu_data, load_data, muldiv_data;
  logic        load_ready, muldiv_ready, hazard, write_en, fwd_valid;
  logic [4:0]  rd_addr, fwd_addr;
  logic [31:0] data, fwd_data;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic        m_write, m_fv;
  logic [4:0]  m_rd, m_fa;
  logic [31:0] m_data, m_fd;
  bit          m_busy [32];

  always #5 clk = ~clk;

  rv32im_writeback #(.XLEN(32), .REG_BITS(5)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .load_valid_i(load_valid), .load_rd_i(load_rd), .load_data_i(load_data),
    .load_ready_o(load_ready),
    .muldiv_valid_i(muldiv_valid), .muldiv_rd_i(muldiv_rd), .muldiv_data_i(muldiv_data),
    .muldiv_ready_o(muldiv_ready),
    .issue_i(issue), .issue_rd_i(issue_rd),
    .rs1_addr_i(rs1), .rs2_addr_i(rs2), .chk_rd_i(chk_rd), .hazard_o(hazard),
    .write_o(write_en), .rd_addr_o(rd_addr), .data_o(data),
    .fwd_valid_o(fwd_valid), .fwd_addr_o(fwd_addr), .fwd_data_o(fwd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    alu_valid = 0; load_valid = 0; muldiv_valid = 0; issue = 0;
    alu_rd = 0; load_rd = 0; muldiv_rd = 0; issue_rd = 0;
    alu_data = 0; load_data = 0; muldiv_data = 0;
    rs1 = 0; rs2 = 0; chk_rd = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs held across the edge.
  task automatic model_step();
    bit          acc, long_lat;
    logic [4:0]  r;
    logic [31:0] d;
    if (!reset_n) begin
      m_write = 0; m_rd = 0; m_data = 0; m_fv = 0; m_fa = 0; m_fd = 0;
      foreach (m_busy[i]) m_busy[i] = 0;
      return;
    end
    m_fv = m_write; m_fa = m_rd; m_fd = m_data;
    acc = 1; long_lat = 0; r = 0; d = 0;
    if (alu_valid) begin r = alu_rd; d = alu_data; end
    else if (load_valid) begin r = load_rd; d = load_data; long_lat = 1; end
    else if (muldiv_valid) begin r = muldiv_rd; d = muldiv_data; long_lat = 1; end
    else acc = 0;
    m_write = acc && (r != 0);
    if (acc) begin m_rd = r; m_data = d; end
    if (long_lat && r != 0) m_busy[r] = 0;
    if (issue && issue_rd != 0) m_busy[issue_rd] = 1;
  endtask

  task automatic check_regs();
    chk("write", {31'b0, write_en}, {31'b0, m_write});
    chk("rd_addr", {27'b0, rd_addr}, {27'b0, m_rd});
    chk("data", data, m_data);
    chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, m_fv});
    chk("fwd_addr", {27'b0, fwd_addr}, {27'b0, m_fa});
    chk("fwd_data", fwd_data, m_fd);
  endtask

  task automatic check_comb();
    #1;
    chk("load_ready", {31'b0, load_ready}, {31'b0, !alu_valid});
    chk("muldiv_ready", {31'b0, muldiv_ready}, {31'b0, !alu_valid && !load_valid});
    chk("hazard", {31'b0, hazard}, {31'b0, m_busy[rs1] | m_busy[rs2] | m_busy[chk_rd]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  initial begin
    idle();
    reset_n = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
    m_write = 0; m_rd = 0; m_data = 0; m_fv = 0; m_fa = 0; m_fd = 0;
    @(negedge clk);
    tick(); tick();
    chk("rst_write", {31'b0, write_en}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    reset_n = 1;

    // ALU write then forward copy
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; check_comb();
    tick(); idle(); check_comb();
    chk("alu_write", {31'b0, write_en}, 32'd1);
    chk("alu_rd", {27'b0, rd_addr}, 32'd5);
    chk("alu_data", data, 32'h1234);
    tick();
    chk("fwd_valid_lit", {31'b0, fwd_valid}, 32'd1);
    chk("fwd_addr_lit", {27'b0, fwd_addr}, 32'd5);

    // Three sources at once drain in priority order
    alu_valid = 1; alu_rd = 1; alu_data = 32'hA;
    load_valid = 1; load_rd = 2; load_data = 32'hB;
    muldiv_valid = 1; muldiv_rd = 3; muldiv_data = 32'hC;
    check_comb();
    chk("prio_lr0", {31'b0, load_ready}, 32'd0);
    chk("prio_mr0", {31'b0, muldiv_ready}, 32'd0);
    tick(); alu_valid = 0; check_comb();
    chk("prio_rd1", {27'b0, rd_addr}, 32'd1);
    chk("prio_lr1", {31'b0, load_ready}, 32'd1);
    chk("prio_mr_still0", {31'b0, muldiv_ready}, 32'd0);
    tick(); load_valid = 0; check_comb();
    chk("prio_rd2", {27'b0, rd_addr}, 32'd2);
    chk("prio_mr1", {31'b0, muldiv_ready}, 32'd1);
    tick(); muldiv_valid = 0; check_comb();
    chk("prio_rd3", {27'b0, rd_addr}, 32'd3);
    chk("prio_data3", data, 32'hC);

    // Pending load on x7
    issue = 1; issue_rd = 7; tick(); idle(); rs1 = 7; check_comb();
    chk("haz7_set", {31'b0, hazard}, 32'd1);
    load_valid = 1; load_rd = 7; load_data = 32'h77; tick();
    load_valid = 0; check_comb();
    chk("haz7_clr", {31'b0, hazard}, 32'd0);
    chk("ld7_write", {31'b0, write_en}, 32'd1);
    chk("ld7_rd", {27'b0, rd_addr}, 32'd7);

    // Reissue of x9 in the same cycle as its muldiv completion
    issue = 1; issue_rd = 9; tick();
    muldiv_valid = 1; muldiv_rd = 9; muldiv_data = 32'h99; tick();
    idle(); rs2 = 9; check_comb();
    chk("haz9_kept", {31'b0, hazard}, 32'd1);
    muldiv_valid = 1; muldiv_rd = 9; tick(); idle(); rs2 = 9; check_comb();
    chk("haz9_clr", {31'b0, hazard}, 32'd0);

    // x0 destinations
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF; tick(); idle();
    chk("x0_nowrite", {31'b0, write_en}, 32'd0);
    issue = 1; issue_rd = 0; tick(); idle(); rs1 = 0; check_comb();
    chk("x0_nohaz", {31'b0, hazard}, 32'd0);

    // Reset with a pending register and a valid load
    issue = 1; issue_rd = 3; tick(); idle();
    load_valid = 1; load_rd = 3; load_data = 32'h33; reset_n = 0; rs1 = 3; check_comb();
    tick(); reset_n = 1; idle(); rs1 = 3; check_comb();
    chk("rst_mid_write", {31'b0, write_en}, 32'd0);
    chk("rst_mid_haz", {31'b0, hazard}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset_n      = ($urandom_range(0, 59) != 0);
      alu_valid    = ($urandom_range(0, 3) == 0);
      load_valid   = ($urandom_range(0, 2) == 0);
      muldiv_valid = ($urandom_range(0, 2) == 0);
      issue        = ($urandom_range(0, 1) == 0);
      alu_rd       = 5'($urandom_range(0, 12));
      load_rd      = 5'($urandom_range(0, 12));
      muldiv_rd    = 5'($urandom_range(0, 12));
      issue_rd     = 5'($urandom_range(0, 12));
      rs1          = 5'($urandom_range(0, 12));
      rs2          = 5'($urandom_range(0, 31));
      chk_rd       = 5'($urandom_range(0, 12));
      alu_data     = $urandom;
      load_data    = $urandom;
      muldiv_data  = $urandom;
      check_comb();
      tick();
    end
    reset_n = 1; idle(); check_comb();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32im_writeback.md
RV32IM_WRITEBACK -- requirements
Module: rv32im_writeback

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter REG_BITS, default 5, register address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1, synchronous, active-low reset.
REQ-005 SHALL have ports alu_valid_i (in, 1), alu_rd_i (in, REG_BITS) and alu_data_i (in, XLEN): ALU result, never back-pressured.
REQ-006 SHALL have ports load_valid_i (in, 1), load_rd_i (in, REG_BITS), load_data_i (in, XLEN) and load_ready_o (out, 1): load-unit result handshake.
REQ-007 SHALL have ports muldiv_valid_i (in, 1), muldiv_rd_i (in, REG_BITS), muldiv_data_i (in, XLEN) and muldiv_ready_o (out, 1): multiply/divide result handshake.
REQ-008 SHALL have ports issue_i (in, 1) and issue_rd_i (in, REG_BITS): decode marks a long-latency (load or muldiv) destination as pending.
REQ-009 SHALL have ports rs1_addr_i, rs2_addr_i and chk_rd_i (in, REG_BITS each), and hazard_o (out, 1): decode operand hazard check.
REQ-010 SHALL have ports write_o (out, 1), rd_addr_o (out, REG_BITS) and data_o (out, XLEN), driving the register-file write port.
REQ-011 SHALL have ports fwd_valid_o (out, 1), fwd_addr_o (out, REG_BITS) and fwd_data_o (out, XLEN): forwarding copy of the previous write.

Function
REQ-012 SHALL arbitrate at most one source per cycle with fixed priority: ALU, then load, then muldiv.
REQ-013 SHALL drive load_ready_o = !alu_valid_i, combinationally.
REQ-014 SHALL drive muldiv_ready_o = !alu_valid_i & !load_valid_i, combinationally.
REQ-015 SHALL define a source as accepted in a cycle when its valid is high and its ready is high; ALU is accepted whenever alu_valid_i is high.
REQ-016 SHALL register the accepted rd and data into rd_addr_o/data_o on the next edge, with latency exactly 1 cycle from acceptance to write_o.
REQ-017 SHALL set write_o = 1 for one cycle per accepted result when rd != 0, and write_o = 0 otherwise.
REQ-018 SHALL accept an x0 destination normally (handshake completes), drop the write, and leave all pending state unchanged.
REQ-019 SHALL hold rd_addr_o and data_o when nothing is accepted, with write_o = 0.
REQ-020 SHALL load fwd_valid_o/fwd_addr_o/fwd_data_o on each edge from write_o/rd_addr_o/data_o, giving a one-cycle-delayed copy that covers the register-file read-after-write latency.
REQ-021 SHALL keep a 2^REG_BITS-bit busy vector; bit 0 is constant 0.
REQ-022 SHALL set busy[issue_rd_i] on an edge where issue_i = 1 and issue_rd_i != 0.
REQ-023 SHALL clear busy[rd] on an edge where a load or muldiv result with that rd is accepted; ALU acceptance never clears busy.
REQ-024 SHALL give set priority over clear when the set and the clear target the same register in the same cycle (back-to-back reissue).
REQ-025 SHALL leave a bit set when issue hits an already-busy register; no count is kept.
REQ-026 SHALL drive hazard_o = busy[rs1_addr_i] | busy[rs2_addr_i] | busy[chk_rd_i], combinationally from the current busy vector (same-cycle clear not bypassed).
REQ-027 SHALL produce no X on any output while valids are low, whatever the data inputs.

Reset
REQ-028 SHALL, on an edge with reset_n_i = 0: set write_o = 0, rd_addr_o = 0, data_o = 0, fwd_valid_o = 0, fwd_addr_o = 0, fwd_data_o = 0 and busy = 0, and accept no result that cycle.
REQ-029 SHALL, with reset asserted mid-operation, discard the in-flight result and all pending bits; ready outputs still follow REQ-013/REQ-014.

Verification
REQ-030 SHALL cover: ALU valid rd=5, data=0x1234 -> next cycle write_o=1, rd_addr_o=5, data_o=0x1234; following cycle fwd_valid_o=1, fwd_addr_o=5.
REQ-031 SHALL cover: ALU, load and muldiv all valid -> ALU written, load_ready_o=0 and muldiv_ready_o=0; next cycle (ALU idle) load accepted, muldiv_ready_o=0; muldiv accepted the cycle after.
REQ-032 SHALL cover: issue rd=7 -> hazard_o=1 for rs1_addr_i=7; load result rd=7 accepted -> hazard_o=0 the following cycle, write_o=1 with rd_addr_o=7.
REQ-033 SHALL cover: same cycle issue rd=9 and muldiv accept rd=9 -> busy[9] stays 1.
REQ-034 SHALL cover: ALU rd=0, data=0xFFFF_FFFF -> write_o stays 0; issue rd=0 -> hazard_o stays 0 with rs1_addr_i=0.
REQ-035 SHALL cover: busy[3]=1 and load valid, then reset_n_i=0 for one cycle -> write_o=0, busy all 0, hazard_o=0 after the reset edge.
